am_insert_tx: RTL and testbench

Multi-lane alignment-marker inserter for the multi-lane PCS transmit path. Sits between the block distributor and the per-lane scramblers/gearboxes. Owns the marker period counter, so marker slots are not supplied by the caller. For each of LANE_N lanes it:
- stalls upstream for one slot per period;
- builds the lane's marker with its running Bit Interleaved Parity (BIP);
- tracks BIP over every transmitted block.

---
 rtl/am_insert_if.sv | 33 +++
 rtl/am_insert_tx.sv | 136 +++++++++++++
 tb/tb_am_insert_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/am_insert_if.sv
// Block stream between the distributor and the lane gearboxes. It carries the
// upstream valid/ready/data path and the registered marker-tagged output stream.
interface am_insert_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66
);
    logic                        in_v;
    logic                        in_ready;
    logic [LANE_N*BLOCK_W-1:0]   data_i;
    logic                        out_v;
    logic                        marker_o;
    logic [LANE_N*BLOCK_W-1:0]   data_o;

    // Producer of blocks and consumer of the marked stream
    modport master (
        output in_v,
        output data_i,
        input  in_ready,
        input  out_v,
        input  marker_o,
        input  data_o
    );

    // The inserter itself
    modport slave (
        input  in_v,
        input  data_i,
        output in_ready,
        output out_v,
        output marker_o,
        output data_o
    );
endinterface

// File: rtl/am_insert_tx.sv
// Multi-lane alignment-marker inserter. A free-running period counter reserves
// one marker slot per period (upstream stalled), each lane's marker carries
// the BIP of the previous marker plus all data blocks sent since it.
module am_insert_tx #(
    parameter int LANE_N  = 4,
    parameter int HEAD_W  = 2,
    parameter int DATA_W  = 64,
    parameter int BLOCK_W = HEAD_W + DATA_W,
    parameter int GAP     = 16383,
    parameter int CNT_W   = $clog2(GAP + 1),
    parameter logic [LANE_N*64-1:0] LANE_ENC = {
        64'h00C2865D_003D79A2,
        64'h00649A3A_009B65C5,
        64'h00193B0F_00E6C4F0,
        64'h00B8896F_00477690
    }
) (
    input  logic       clk,
    input  logic       nreset,
    am_insert_if.slave bus
);

    // Bit-interleaved parity of one block: payload bit j feeds BIP[(j-2) mod 8],
    // sync header bit 0 feeds BIP[3] and bit 1 feeds BIP[4].
    function automatic logic [7:0] f_bip(input logic [BLOCK_W-1:0] blk);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < BLOCK_W; j++) begin
            if (j == 0) begin
                p[3] = p[3] ^ blk[j];
            end else if (j == 1) begin
                p[4] = p[4] ^ blk[j];
            end else begin
                p[(j - 2) % 8] = p[(j - 2) % 8] ^ blk[j];
            end
        end
        return p;
    endfunction

    // Period state and registered outputs
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_nreset_q;
    logic                      r_out_v;
    logic                      r_marker;
    logic [LANE_N*BLOCK_W-1:0] r_data;

    // Slot decode and next-state values
    logic                      w_marker_slot;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_xfer;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [LANE_N*BLOCK_W-1:0] w_data_next;
    logic [LANE_N*BLOCK_W-1:0] w_marker_blk;

    // cnt==0 is the marker slot; the registered reset copy keeps ready low on
    // the first cycle out of reset regardless of the counter.
    assign w_marker_slot = (r_cnt == '0);
    assign w_in_ready    = r_nreset_q && !w_marker_slot;
    assign w_accept      = bus.in_v && w_in_ready;
    assign w_xfer        = w_marker_slot || w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < LANE_N; gi++) begin : g_lane
            localparam logic [63:0] ENC = LANE_ENC[64*gi +: 64];

            logic [7:0] r_bip;
            logic [7:0] w_bip_next;

            // Marker block: BIP3 in byte 3, its complement in byte 7
            assign w_marker_blk[gi*BLOCK_W +: BLOCK_W] =
                {~r_bip, ENC[55:32], r_bip, ENC[23:0], 2'b10};

            // A marker restarts the parity with itself; data accumulates; idle holds
            always_comb begin
                w_bip_next = r_bip;
                if (w_marker_slot) begin
                    w_bip_next = f_bip(w_marker_blk[gi*BLOCK_W +: BLOCK_W]);
                end else if (w_accept) begin
                    w_bip_next = r_bip ^ f_bip(bus.data_i[gi*BLOCK_W +: BLOCK_W]);
                end
            end

            // Per-lane running parity register
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    r_bip <= '0;
                end else begin
                    r_bip <= w_bip_next;
                end
            end
        end
    endgenerate

    // Next counter value and next output block for the current slot
    always_comb begin
        w_cnt_next  = r_cnt;
        w_data_next = r_data;
        if (w_marker_slot) begin
            w_cnt_next  = CNT_W'(1);
            w_data_next = w_marker_blk;
        end else if (w_accept) begin
            w_cnt_next  = (r_cnt == CNT_W'(GAP)) ? '0 : r_cnt + 1'b1;
            w_data_next = bus.data_i;
        end
    end

    // State and output registers; reset drops any partial period
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt      <= '0;
            r_nreset_q <= 1'b0;
            r_out_v    <= 1'b0;
            r_marker   <= 1'b0;
            r_data     <= '0;
        end else begin
            r_nreset_q <= 1'b1;
            r_out_v    <= w_xfer;
            r_marker   <= w_marker_slot;
            if (w_xfer) begin
                r_cnt  <= w_cnt_next;
                r_data <= w_data_next;
            end
        end
    end

    // Drive the bus from registered state
    always_comb begin
        bus.in_ready = w_in_ready;
        bus.out_v    = r_out_v;
        bus.marker_o = r_marker;
        bus.data_o   = r_data;
    end

endmodule

// File: tb/tb_am_insert_tx.sv
// Bench for am_insert_tx: two instances (GAP=4 and GAP=7) share stimulus.
// A reference model keeps the list of blocks sent since the last marker and
// folds their parity when it predicts the next marker.
module tb_am_insert_tx;
    localparam int LN   = 4;
    localparam int BW   = 66;
    localparam int AW   = LN * BW;
    localparam int GAP0 = 4;
    localparam int GAP1 = 7;
    localparam logic [255:0] ENC = {
        64'h00C2865D003D79A2, 64'h00649A3A009B65C5,
        64'h00193B0F00E6C4F0, 64'h00B8896F00477690
    };

    logic             clk;
    logic             nreset;
    logic             in_v;
    logic [AW-1:0]    data_in;
    logic [1:0]       o_v;
    logic [1:0]       o_m;
    logic [1:0]       o_r;
    logic [1:0][AW-1:0] o_d;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one slot per instance
    logic [AW-1:0] hist [2][8];
    int            hcnt [2];
    int            ndata [2];
    bit            mslot [2];
    logic [AW-1:0] e_d [2];
    logic          e_v [2];
    logic          e_m [2];
    logic          e_r [2];
    bit            mvalid = 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        am_insert_if #(.LANE_N(LN), .BLOCK_W(BW)) ifc ();
        assign ifc.in_v   = in_v;
        assign ifc.data_i = data_in;
        assign o_v[gi]    = ifc.out_v;
        assign o_m[gi]    = ifc.marker_o;
        assign o_r[gi]    = ifc.in_ready;
        assign o_d[gi]    = ifc.data_o;
        am_insert_tx #(.LANE_N(LN), .GAP(gi == 0 ? GAP0 : GAP1)) dut (
            .clk    (clk),
            .nreset (nreset),
            .bus    (ifc)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) data_in[i*32 +: 32] = $urandom;
        data_in[AW-1:256] = 8'($urandom);
    endtask

    task automatic wait_marker(output int n);
        n = 0;
        while (o_m[0] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    function automatic logic [7:0] ob(input int l, input int b);
        return o_d[0][l*BW + 8*b + 2 +: 8];
    endfunction

    function automatic logic [7:0] par8(input logic [BW-1:0] b);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < BW; j++) begin
            if (b[j]) begin
                if (j >= 2)      p[(j - 2) % 8] = ~p[(j - 2) % 8];
                else if (j == 0) p[3] = ~p[3];
                else             p[4] = ~p[4];
            end
        end
        return p;
    endfunction

    function automatic logic [AW-1:0] model_marker(input int k);
        logic [AW-1:0]  m;
        logic [255:0]   enc_all;
        logic [63:0]    enc;
        logic [7:0]     bip;
        enc_all = ENC;
        m = '0;
        for (int l = 0; l < LN; l++) begin
            bip = '0;
            for (int i = 0; i < hcnt[k]; i++) bip = bip ^ par8(hist[k][i][l*BW +: BW]);
            enc = enc_all[l*64 +: 64];
            m[l*BW +: BW] = {~bip, enc[55:32], bip, enc[23:0], 2'b10};
        end
        return m;
    endfunction

    // Model: predict each instance's outputs from the inputs seen at each edge
    initial begin
        logic [AW-1:0] mk;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!nreset) begin
                    e_v[k] = 1'b0; e_m[k] = 1'b0; e_d[k] = '0;
                    mslot[k] = 1'b1; ndata[k] = 0; hcnt[k] = 0;
                end else if (mslot[k]) begin
                    mk = model_marker(k);
                    e_d[k] = mk; e_v[k] = 1'b1; e_m[k] = 1'b1;
                    hist[k][0] = mk; hcnt[k] = 1; ndata[k] = 0; mslot[k] = 1'b0;
                end else if (in_v) begin
                    e_d[k] = data_in; e_v[k] = 1'b1; e_m[k] = 1'b0;
                    hist[k][hcnt[k]] = data_in; hcnt[k]++; ndata[k]++;
                    if (ndata[k] == (k == 0 ? GAP0 : GAP1)) mslot[k] = 1'b1;
                end else begin
                    e_v[k] = 1'b0; e_m[k] = 1'b0;
                end
                e_r[k] = !mslot[k];
            end
            if (!nreset) mvalid = 1'b1;
        end
    end

    // Scoreboard: compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("dut%0d_out_v", k),    AW'(o_v[k]), AW'(e_v[k]));
                    check($sformatf("dut%0d_marker_o", k), AW'(o_m[k]), AW'(e_m[k]));
                    check($sformatf("dut%0d_in_ready", k), AW'(o_r[k]), AW'(e_r[k]));
                    check($sformatf("dut%0d_data_o", k),   o_d[k],      e_d[k]);
                end
            end
        end
    end

    // Directed sequence followed by the long random run
    initial begin
        int n;
        nreset  = 1'b0;
        in_v    = 1'b1;
        data_in = '0;
        repeat (3) step();
        check("rst_out_v",    AW'(o_v[0]), AW'(1'b0));
        check("rst_marker_o", AW'(o_m[0]), AW'(1'b0));
        check("rst_in_ready", AW'(o_r[0]), AW'(1'b0));
        check("rst_data_o",   o_d[0],      '0);
        nreset = 1'b1;

        // Cycle c after release: ready 0 on c%5==1, marker out on c%5==2
        for (int c = 1; c <= 12; c++) begin
            check("t2_in_ready", AW'(o_r[0]), AW'((c % 5 == 1) ? 1'b0 : 1'b1));
            check("t2_marker_o", AW'(o_m[0]), AW'((c % 5 == 2) ? 1'b1 : 1'b0));
            if (c == 2) check("t1_marker_lane0", AW'(o_d[0][BW-1:0]), AW'({64'hFFB8896F00477690, 2'b10}));
            if (c >= 3 && c <= 6) check("t1_zero_pass", o_d[0], '0);
            if (c == 7) begin
                check("t1_bip3", AW'(ob(0, 3)), AW'(8'h10));
                check("t1_bip7", AW'(ob(0, 7)), AW'(8'hEF));
            end
            step();
        end

        // Three idle cycles after the first data block of the period
        in_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_idle_out_v", AW'(o_v[0]), AW'(1'b0));
        end
        in_v = 1'b1;
        wait_marker(n);
        check("t3_marker_delay", AW'(n), AW'(4));
        check("t3_bip3", AW'(ob(0, 3)), AW'(8'h10));

        // One block with only bit 0 of lane 2 set
        data_in[2*BW] = 1'b1;
        step();
        data_in = '0;
        wait_marker(n);
        check("t4_marker_wait", AW'(n), AW'(4));
        for (int l = 0; l < LN; l++) begin
            check($sformatf("t4_bip3_lane%0d", l), AW'(ob(l, 3)), AW'(l == 2 ? 8'h18 : 8'h10));
            check($sformatf("t4_bip7_lane%0d", l), AW'(ob(l, 7)), AW'(l == 2 ? 8'hE7 : 8'hEF));
        end

        // Reset for one cycle with cnt=2 and non-zero parity
        rand_data();
        step();
        nreset = 1'b0;
        step();
        check("t5_out_v",    AW'(o_v[0]), AW'(1'b0));
        check("t5_marker_o", AW'(o_m[0]), AW'(1'b0));
        check("t5_data_o",   o_d[0],      '0);
        check("t5_in_ready", AW'(o_r[0]), AW'(1'b0));
        nreset  = 1'b1;
        data_in = '0;
        check("t5_ready_release", AW'(o_r[0]), AW'(1'b0));
        step();
        check("t5_first_marker", AW'(o_m[0]), AW'(1'b1));
        for (int l = 0; l < LN; l++) begin
            check($sformatf("t5_bip3_lane%0d", l), AW'(ob(l, 3)), AW'(8'h00));
            check($sformatf("t5_bip7_lane%0d", l), AW'(ob(l, 7)), AW'(8'hFF));
        end

        // Random traffic until the GAP=7 instance has emitted 1000 markers
        n = 0;
        for (int cyc = 0; cyc < 20000 && n < 1000; cyc++) begin
            in_v = ($urandom_range(3) != 0);
            rand_data();
            step();
            if (o_m[1] === 1'b1) n++;
        end
        check("t6_markers", AW'(n), AW'(1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
